// File: rtl/lut5_table_builder.sv
// Run-time generator for a 2^AW-entry table of (k*C) mod Q, filled by repeated modular addition.
// Reads behave like a registered ROM: one cycle of latency, old data on a same-address write.
module lut5_table_builder #(
    parameter int            W  = 49,
    parameter int            AW = 5,
    parameter logic [W-1:0]  Q  = 49'd549824583172097
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  const_in,
    output logic          busy,
    output logic          done,
    output logic          table_valid,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  c_reg;
    logic [W-1:0]  cr_reg;
    logic [W-1:0]  acc_reg;
    logic [AW-1:0] k_reg;
    logic          done_reg;
    logic          valid_reg;
    logic [W-1:0]  rd_data_reg;

    logic [W-1:0]  ram [0:DEPTH-1];

    logic [W-1:0]  cr_next;
    logic [W:0]    sum;
    logic [W:0]    sum_red;
    logic [W-1:0]  acc_next;

    // Both operands are below Q and 2^W <= 2Q, so one conditional subtract suffices everywhere.
    always_comb begin
        cr_next  = (c_reg >= Q) ? (c_reg - Q) : c_reg;
        sum      = {1'b0, acc_reg} + {1'b0, cr_reg};
        sum_red  = sum - {1'b0, Q};
        acc_next = (sum >= {1'b0, Q}) ? sum_red[W-1:0] : sum[W-1:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = FILL;
            FILL:    if (k_reg == {AW{1'b1}}) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            c_reg       <= '0;
            cr_reg      <= '0;
            acc_reg     <= '0;
            k_reg       <= '0;
            done_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            done_reg    <= (state_reg == DONE);
            rd_data_reg <= ram[rd_addr];
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        c_reg     <= const_in;
                        valid_reg <= 1'b0;
                    end
                end
                LOAD: begin
                    cr_reg  <= cr_next;
                    acc_reg <= '0;
                    k_reg   <= '0;
                end
                FILL: begin
                    acc_reg <= acc_next;
                    k_reg   <= k_reg + 1'b1;
                end
                DONE: valid_reg <= 1'b1;
                default: ;
            endcase
        end
    end

    // Table storage is never reset; a write is suppressed on the edge a reset aborts the fill.
    always_ff @(posedge clk) begin
        if (!rst && state_reg == FILL)
            ram[k_reg] <= acc_reg;
    end

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign table_valid = valid_reg;
    assign rd_data     = rd_data_reg;

endmodule

// File: tb/tb_lut5_table_builder.sv
// Randomised self-checking bench for lut5_table_builder against a direct (k*C) mod Q reference table.
module tb_lut5_table_builder;
    localparam int W  = 49;
    localparam int AW = 5;
    localparam longint unsigned Q     = 64'd549824583172097;
    localparam longint unsigned WMASK = (64'd1 << W) - 64'd1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  const_in;
    logic          busy;
    logic          done;
    logic          table_valid;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;

    int checks = 0;
    int errors = 0;

    longint unsigned model_tab [32];
    longint unsigned old_tab   [32];

    lut5_table_builder dut (
        .clk(clk), .rst(rst), .start(start), .const_in(const_in),
        .busy(busy), .done(done), .table_valid(table_valid),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void set_model(input longint unsigned c);
        for (int k = 0; k < 32; k++) begin
            old_tab[k]   = model_tab[k];
            model_tab[k] = (longint'(k) * c) % Q;
        end
    endfunction

    // Start a build with C=c; optionally pulse a second start at cycle extra_at,
    // and optionally probe read-before-write at address rbw_k during the fill.
    task automatic build(input longint unsigned c, input int extra_at,
                         input longint unsigned extra_c, input int rbw_k);
        int cnt;
        int vbad;
        int dn;
        vbad = 0;
        set_model(c);
        start = 1'b1;
        const_in = c[W-1:0];
        tick();
        start = 1'b0;
        cnt = 1;
        check("busy_rise", busy, 1);
        check("valid_drop", table_valid, 0);
        while (done !== 1'b1 && cnt < 100) begin
            if (busy && table_valid) vbad++;
            if (cnt == extra_at) begin
                start = 1'b1;
                const_in = extra_c[W-1:0];
            end
            if (rbw_k >= 0 && cnt == 2 + rbw_k) rd_addr = rbw_k[AW-1:0];
            tick();
            start = 1'b0;
            cnt++;
            if (rbw_k >= 0 && cnt == 3 + rbw_k) check("rbw_old", rd_data, old_tab[rbw_k]);
            if (rbw_k >= 0 && cnt == 4 + rbw_k) check("rbw_new", rd_data, model_tab[rbw_k]);
        end
        check("latency", cnt, 35);
        check("valid_during_busy", vbad, 0);
        check("valid_at_done", table_valid, 1);
        check("busy_at_done", busy, 0);
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dn++;
        end
        check("done_single", dn, 0);
    endtask

    task automatic readback(input string tag);
        for (int k = 0; k < 32; k++) begin
            rd_addr = k[AW-1:0];
            tick();
            check(tag, rd_data, model_tab[k]);
        end
    endtask

    task automatic read_one(input int k, input longint unsigned exp);
        rd_addr = k[AW-1:0];
        tick();
        check("spec_entry", rd_data, exp);
    endtask

    initial begin
        longint unsigned c;
        int rk;
        rst = 1'b1; start = 1'b0; const_in = '0; rd_addr = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", table_valid, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) model_tab[k] = 0;

        // Directed constant with published entries
        build(64'd420011847974880, -1, 0, -1);
        read_one(0, 64'd0);
        read_one(1, 64'd420011847974880);
        read_one(2, 64'd290199112777663);
        read_one(4, 64'd30573642383229);
        read_one(31, 64'd374401874263049);
        readback("tab_c1");

        // C equal to Q and the all-ones constant
        build(Q, -1, 0, -1);
        readback("tab_q");
        build(WMASK, -1, 0, -1);
        read_one(1, 64'd13125370249214);
        read_one(2, 64'd26250740498428);
        readback("tab_ones");

        // Second start mid-fill must be ignored
        build(64'd123456789012345, 12, 64'd987654321, -1);
        readback("tab_ignore");
        build(64'd987654321, -1, 0, -1);
        readback("tab_rebuild");

        // Reset during FILL
        start = 1'b1; const_in = 49'd77777777777; tick(); start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_valid", table_valid, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) check("abort_no_done", done, 0);
        end
        check("abort_idle", busy, 0);
        build(64'd314159265358979, -1, 0, -1);
        readback("tab_after_abort");

        // Random constants with read-before-write probes
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0:       c = Q - 64'($urandom_range(0, 8));
                1:       c = WMASK - 64'($urandom_range(0, 8));
                default: c = {$urandom, $urandom} & WMASK;
            endcase
            rk = $urandom_range(1, 31);
            build(c, -1, 0, rk);
            readback("tab_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
